uart_reg_bank: RTL and testbench
================================

# uart_reg_bank

Parametrised UART register bank that replaces the fixed four-channel mapper between the UART packet receiver and the pattern PWM/DAC channels. It decodes each received packet into per-channel shadow registers and supports broadcast writes. Masked commits copy shadow to active registers atomically, deferred while a channel is busy. Every packet is answered with a byte-stream acknowledge or readback frame for the UART transmitter.

## Interface
- NUM_CHANNELS, 4, channel count; legal 1..8.
- PAT_WIDTH, 32, pattern register width; legal 8, 16, 24, 32.
- Derived: PAT_BYTES = PAT_WIDTH/8; RB_LEN = 9 + PAT_BYTES (readback frame length).

Ports:
- clk_50M  in  1  system clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- func_reg  in  8  packet function code.
- rev_data  in  88  packet payload; rev_data1 = [7:0] … rev_data11 = [87:80].
- pack_done  in  1  one-cycle strobe; func_reg/rev_data valid this cycle.
- ch_busy  in  NUM_CHANNELS  channel i busy (PWM/DAC busy outputs).
- hs_ctrl_sta  out  8*N  active control, channel i at [8i+7:8i].
- duty_num  out  8*N  active duty count.
- pulse_dessert  out  16*N  active pulse gap.
- pulse_num  out  8*N  active pulse count.
- pat  out  PAT_WIDTH*N  active pattern.
- ls_ctrl_sta  out  8*N  active LS control.
- commit_pending  out  NUM_CHANNELS  deferred commit outstanding.
- tx_data  out  8  response byte.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  transmitter accepts byte when tx_valid & tx_ready.
- resp_busy  out  1  response frame in progress.
- drop_cnt  out  8  saturating count of suppressed responses.

## Operation
- Reset: all shadow and active registers, commit_pending, tx_data, tx_valid, resp_busy, drop_cnt = 0; FSM to IDLE.
- Decode on pack_done; ch = rev_data1. Status: 0x00 OK, 0x01 bad channel, 0x02 bad function.
- 0x01 HS write: ch < N or ch = 0xFF (broadcast, all channels). Shadow hs_ctrl_sta = rev_data2, duty_num = rev_data3, pulse_dessert = {rev_data4, rev_data5}, pulse_num = rev_data6, pat = concatenation of rev_data7..rev_data(6+PAT_BYTES), rev_data7 most significant. Other ch: no write, status 0x01.
- 0x02 LS write: same channel rule; shadow ls_ctrl_sta = rev_data2.
- 0x03 commit: rev_data1 is a channel mask; bits ≥ N are ignored. For each masked channel:
  - not busy: copy all shadow to active next edge;
  - busy: set commit_pending[i]; copy on the first edge where ch_busy[i] = 0, using shadow contents at that edge, then clear pending.
  - Mask 0 is a no-op with status 0x00.
  - A repeat commit to a pending channel leaves it pending.
- 0x04 readback: ch < N returns active registers; otherwise status 0x01 with an ack frame.
- Other func codes: no register effect, status 0x02.
- Ack frame (3 bytes): 0xA5, func_reg, status.
- Readback frame (RB_LEN bytes): 0xA5, 0x04, 0x00, hs_ctrl_sta, duty_num, pulse_dessert[15:8], pulse_dessert[7:0], pulse_num, pat MSB-first, ls_ctrl_sta. Contents are snapshotted at the decode cycle.
- Response FSM:
  - IDLE → SEND on pack_done.
  - SEND advances a byte index on each tx handshake; after the last byte, back to IDLE.
  - tx_data is stable while tx_valid & !tx_ready.
- pack_done while resp_busy: register effects still apply; the response is suppressed; drop_cnt increments, saturating at 0xFF.

## Timing
- pack_done at edge T: shadow writes and commit copies of non-busy channels visible after T+1. tx_valid = 1 with byte 0 after T+1; resp_busy = 1 over the same span.
- One byte per cycle when tx_ready is held high. Ack frame occupies 3 cycles; resp_busy falls after the last handshake edge.
- Deferred commit: active updates on the edge where ch_busy[i] is sampled low; commit_pending[i] clears on that same edge.
- Deferred commit and shadow write on the same edge: active takes the pre-write shadow value.
- rst_n low mid-frame: tx_valid = 0 and all registers cleared after the next edge; no partial-frame resume.
- Active outputs change only on commit edges, never on writes.

## Test plan
- Reset then HS write (ch 2, rev_data2..10 = 01,40,00,10,05,DE,AD,BE,EF) → shadow updated, active unchanged, ack A5 01 00. Commit mask 0x04 → pat[2] = 0xDEADBEEF, duty_num[2] = 0x40, ack A5 03 00.
- HS write with ch = 0xFF, duty 0x22, then commit mask 0xFF → all N duty_num = 0x22; ch 9 write → status 0x01, no change.
- ch_busy[1] = 1 during commit mask 0x02 → commit_pending[1] = 1, active unchanged. New shadow write duty 0x33. Drop busy → active duty_num[1] = 0x33 on that edge, pending cleared.
- Readback ch 0 with tx_ready toggling 1/0 → exactly RB_LEN bytes A5 04 00 … in order, each byte held stable until accepted.
- Second pack_done during an outstanding frame → register effect applied, no extra frame, drop_cnt = 1. After 300 such drops → drop_cnt = 0xFF.
- func 0x07 → ack A5 07 02, no register change. Assert rst_n low mid-readback → tx_valid low and all outputs 0 next cycle.

Source files
------------

// File: rtl/uart_reg_bank.sv
// UART register bank: decodes received packets into per-channel shadow registers,
// commits shadow to active (deferred while busy) and streams ack/readback frames.
module uart_reg_bank #(
  parameter int unsigned NUM_CHANNELS = 4,
  parameter int unsigned PAT_WIDTH    = 32
) (
  input  logic                              clk_50M,
  input  logic                              rst_n,
  input  logic [7:0]                        func_reg,
  input  logic [87:0]                       rev_data,
  input  logic                              pack_done,
  input  logic [NUM_CHANNELS-1:0]           ch_busy,
  output logic [8*NUM_CHANNELS-1:0]         hs_ctrl_sta,
  output logic [8*NUM_CHANNELS-1:0]         duty_num,
  output logic [16*NUM_CHANNELS-1:0]        pulse_dessert,
  output logic [8*NUM_CHANNELS-1:0]         pulse_num,
  output logic [PAT_WIDTH*NUM_CHANNELS-1:0] pat,
  output logic [8*NUM_CHANNELS-1:0]         ls_ctrl_sta,
  output logic [NUM_CHANNELS-1:0]           commit_pending,
  output logic [7:0]                        tx_data,
  output logic                              tx_valid,
  input  logic                              tx_ready,
  output logic                              resp_busy,
  output logic [7:0]                        drop_cnt
);

  localparam int unsigned N         = NUM_CHANNELS;
  localparam int unsigned PAT_BYTES = PAT_WIDTH / 8;
  localparam int unsigned RB_LEN    = 9 + PAT_BYTES;
  localparam int unsigned IDX_W     = $clog2(RB_LEN);

  localparam logic [7:0] FN_HS     = 8'h01;
  localparam logic [7:0] FN_LS     = 8'h02;
  localparam logic [7:0] FN_COMMIT = 8'h03;
  localparam logic [7:0] FN_RB     = 8'h04;
  localparam logic [7:0] ACK_OK    = 8'h00;
  localparam logic [7:0] ACK_BADCH = 8'h01;
  localparam logic [7:0] ACK_BADFN = 8'h02;
  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef struct packed {
    logic [7:0]           hs;
    logic [7:0]           duty;
    logic [15:0]          gap;
    logic [7:0]           pnum;
    logic [PAT_WIDTH-1:0] pat;
    logic [7:0]           ls;
  } ch_regs_t;

  typedef enum logic {ST_IDLE, ST_SEND} state_t;

  ch_regs_t             shadow_q [N];
  ch_regs_t             active_q [N];
  logic [N-1:0]         pending_q;
  logic [7:0]           frame_q  [RB_LEN];
  logic [IDX_W-1:0]     idx_q;
  logic [IDX_W-1:0]     last_q;
  state_t               state_q, state_nxt;

  logic [7:0]           ch_c;
  logic                 ch_ok_c;
  logic                 bcast_c;
  logic [N-1:0]         wr_sel_c;
  logic [N-1:0]         commit_c;
  logic [N-1:0]         copy_c;
  logic [7:0]           status_c;
  logic                 rb_ok_c;
  logic [PAT_WIDTH-1:0] pkt_pat_c;
  ch_regs_t             rb_c;
  logic [7:0]           frame_c  [RB_LEN];
  logic [IDX_W-1:0]     last_c;
  logic                 hs_c;
  logic                 accept_c;
  logic                 last_hs_c;
  logic                 unused_ok;

  // rev_data11 and pattern bytes beyond PAT_BYTES carry nothing for this block
  assign unused_ok = ^rev_data;

  // Packet decode: write selects, commit mask and response status
  always_comb begin
    ch_c     = rev_data[7:0];
    ch_ok_c  = ch_c < 8'(N);
    bcast_c  = ch_c == 8'hFF;
    wr_sel_c = '0;
    commit_c = '0;
    status_c = ACK_OK;
    rb_ok_c  = 1'b0;
    case (func_reg)
      FN_HS, FN_LS: begin
        for (int i = 0; i < int'(N); i++)
          wr_sel_c[i] = pack_done && (bcast_c || ch_c == 8'(i));
        if (!(ch_ok_c || bcast_c)) status_c = ACK_BADCH;
      end
      FN_COMMIT: commit_c = pack_done ? rev_data[N-1:0] : '0;
      FN_RB: begin
        if (ch_ok_c) rb_ok_c = 1'b1;
        else         status_c = ACK_BADCH;
      end
      default: status_c = ACK_BADFN;
    endcase
    for (int i = 0; i < int'(N); i++)
      copy_c[i] = !ch_busy[i] && (pending_q[i] || commit_c[i]);
  end

  // Pattern payload, rev_data7 most significant
  always_comb begin
    pkt_pat_c = '0;
    for (int b = 0; b < int'(PAT_BYTES); b++)
      pkt_pat_c[PAT_WIDTH-1-8*b -: 8] = rev_data[8*(7+b)-1 -: 8];
  end

  // Response frame image, snapshotting active registers at the decode cycle
  always_comb begin
    rb_c = active_q[0];
    for (int i = 0; i < int'(N); i++)
      if (ch_c == 8'(i)) rb_c = active_q[i];
    for (int k = 0; k < int'(RB_LEN); k++) frame_c[k] = 8'h00;
    frame_c[0] = SYNC_BYTE;
    frame_c[1] = func_reg;
    frame_c[2] = status_c;
    last_c     = IDX_W'(2);
    if (rb_ok_c) begin
      frame_c[3] = rb_c.hs;
      frame_c[4] = rb_c.duty;
      frame_c[5] = rb_c.gap[15:8];
      frame_c[6] = rb_c.gap[7:0];
      frame_c[7] = rb_c.pnum;
      for (int b = 0; b < int'(PAT_BYTES); b++)
        frame_c[8+b] = rb_c.pat[PAT_WIDTH-1-8*b -: 8];
      frame_c[8+PAT_BYTES] = rb_c.ls;
      last_c = IDX_W'(RB_LEN - 1);
    end
  end

  // Shadow writes and commits; a same-edge commit copies the pre-write shadow
  always_ff @(posedge clk_50M) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(N); i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
      pending_q <= '0;
    end else begin
      for (int i = 0; i < int'(N); i++) begin
        if (copy_c[i]) begin
          active_q[i]  <= shadow_q[i];
          pending_q[i] <= 1'b0;
        end else if (commit_c[i]) begin
          pending_q[i] <= 1'b1;
        end
        if (wr_sel_c[i]) begin
          if (func_reg == FN_HS) begin
            shadow_q[i].hs   <= rev_data[15:8];
            shadow_q[i].duty <= rev_data[23:16];
            shadow_q[i].gap  <= {rev_data[31:24], rev_data[39:32]};
            shadow_q[i].pnum <= rev_data[47:40];
            shadow_q[i].pat  <= pkt_pat_c;
          end else begin
            shadow_q[i].ls   <= rev_data[15:8];
          end
        end
      end
    end
  end

  always_ff @(posedge clk_50M) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    accept_c  = 1'b0;
    last_hs_c = 1'b0;
    hs_c      = tx_valid && tx_ready;
    case (state_q)
      ST_IDLE: begin
        if (pack_done) begin
          state_nxt = ST_SEND;
          accept_c  = 1'b1;
        end
      end
      ST_SEND: begin
        if (hs_c && idx_q == last_q) begin
          state_nxt = ST_IDLE;
          last_hs_c = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Transmit datapath; tx_data only moves on a handshake
  always_ff @(posedge clk_50M) begin
    if (!rst_n) begin
      tx_data   <= 8'h00;
      tx_valid  <= 1'b0;
      resp_busy <= 1'b0;
      drop_cnt  <= 8'h00;
      idx_q     <= '0;
      last_q    <= '0;
      for (int k = 0; k < int'(RB_LEN); k++) frame_q[k] <= 8'h00;
    end else begin
      if (accept_c) begin
        frame_q   <= frame_c;
        last_q    <= last_c;
        idx_q     <= '0;
        tx_data   <= frame_c[0];
        tx_valid  <= 1'b1;
        resp_busy <= 1'b1;
      end else if (last_hs_c) begin
        tx_valid  <= 1'b0;
        resp_busy <= 1'b0;
      end else if (state_q == ST_SEND && hs_c) begin
        idx_q   <= idx_q + IDX_W'(1);
        tx_data <= frame_q[idx_q + IDX_W'(1)];
      end
      if (pack_done && state_q == ST_SEND && drop_cnt != 8'hFF)
        drop_cnt <= drop_cnt + 8'd1;
    end
  end

  for (genvar g = 0; g < int'(N); g++) begin : g_flat
    assign hs_ctrl_sta[8*g +: 8]            = active_q[g].hs;
    assign duty_num[8*g +: 8]               = active_q[g].duty;
    assign pulse_dessert[16*g +: 16]        = active_q[g].gap;
    assign pulse_num[8*g +: 8]              = active_q[g].pnum;
    assign pat[PAT_WIDTH*g +: PAT_WIDTH]    = active_q[g].pat;
    assign ls_ctrl_sta[8*g +: 8]            = active_q[g].ls;
  end

  assign commit_pending = pending_q;

endmodule

// File: tb/tb_uart_reg_bank.sv
// Randomised bench for uart_reg_bank against a field-level register/frame model.
module tb_uart_reg_bank;

  localparam int unsigned N      = 4;
  localparam int unsigned PW     = 32;
  localparam int unsigned PB     = PW / 8;
  localparam int unsigned RB_LEN = 9 + PB;

  logic            clk_50M = 1'b0;
  logic            rst_n = 1'b0;
  logic [7:0]      func_reg = '0;
  logic [87:0]     rev_data = '0;
  logic            pack_done = 1'b0;
  logic [N-1:0]    ch_busy = '0;
  logic [8*N-1:0]  hs_ctrl_sta, duty_num, pulse_num, ls_ctrl_sta;
  logic [16*N-1:0] pulse_dessert;
  logic [PW*N-1:0] pat;
  logic [N-1:0]    commit_pending;
  logic [7:0]      tx_data;
  logic            tx_valid;
  logic            tx_ready = 1'b0;
  logic            resp_busy;
  logic [7:0]      drop_cnt;

  uart_reg_bank #(.NUM_CHANNELS(N), .PAT_WIDTH(PW)) dut (
    .clk_50M(clk_50M), .rst_n(rst_n), .func_reg(func_reg), .rev_data(rev_data),
    .pack_done(pack_done), .ch_busy(ch_busy), .hs_ctrl_sta(hs_ctrl_sta),
    .duty_num(duty_num), .pulse_dessert(pulse_dessert), .pulse_num(pulse_num),
    .pat(pat), .ls_ctrl_sta(ls_ctrl_sta), .commit_pending(commit_pending),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .resp_busy(resp_busy), .drop_cnt(drop_cnt)
  );

  always #10 clk_50M = ~clk_50M;

  // Model state: shadow/active fields per channel, pending bits, drop counter, expected bytes
  logic [7:0]   m_sh_hs[N], m_sh_duty[N], m_sh_pnum[N], m_sh_ls[N];
  logic [15:0]  m_sh_gap[N];
  logic [PW-1:0] m_sh_pat[N];
  logic [7:0]   m_ac_hs[N], m_ac_duty[N], m_ac_pnum[N], m_ac_ls[N];
  logic [15:0]  m_ac_gap[N];
  logic [PW-1:0] m_ac_pat[N];
  logic [N-1:0] m_pend;
  logic [7:0]   m_drop;
  logic [7:0]   exp_q[$];
  logic         rst_drv = 1'b0;
  logic [N-1:0] busy_v = '0;
  int           chk_cnt = 0;
  int           pass_cnt = 0;
  int           hs_cnt = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [7:0] pkt_byte(input logic [87:0] d, input int k);
    return d[8*k-1 -: 8];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < int'(N); i++) begin
      m_sh_hs[i] = 0; m_sh_duty[i] = 0; m_sh_pnum[i] = 0; m_sh_ls[i] = 0;
      m_sh_gap[i] = 0; m_sh_pat[i] = 0;
      m_ac_hs[i] = 0; m_ac_duty[i] = 0; m_ac_pnum[i] = 0; m_ac_ls[i] = 0;
      m_ac_gap[i] = 0; m_ac_pat[i] = 0;
    end
    m_pend = 0;
    m_drop = 0;
    exp_q.delete();
  endtask

  task automatic push_frame(input logic [7:0] fn, input logic [87:0] d);
    int c;
    logic [7:0] st;
    c = int'(d[7:0]);
    if (fn == 8'h01 || fn == 8'h02) st = (c < int'(N) || c == 255) ? 8'h00 : 8'h01;
    else if (fn == 8'h03) st = 8'h00;
    else if (fn == 8'h04) st = (c < int'(N)) ? 8'h00 : 8'h01;
    else st = 8'h02;
    exp_q.push_back(8'hA5);
    exp_q.push_back(fn);
    exp_q.push_back(st);
    if (fn == 8'h04 && c < int'(N)) begin
      exp_q.push_back(m_ac_hs[c]);
      exp_q.push_back(m_ac_duty[c]);
      exp_q.push_back(m_ac_gap[c][15:8]);
      exp_q.push_back(m_ac_gap[c][7:0]);
      exp_q.push_back(m_ac_pnum[c]);
      for (int b = 0; b < int'(PB); b++) exp_q.push_back(m_ac_pat[c][PW-1-8*b -: 8]);
      exp_q.push_back(m_ac_ls[c]);
    end
  endtask

  task automatic model_edge(input logic pd, input logic [7:0] fn, input logic [87:0] d,
                            input logic hs, input logic [7:0] hb, input logic busy_pre);
    logic req;
    if (hs) begin
      if (exp_q.size() == 0) check("tx_unexpected_byte", 1, 0);
      else check("tx_byte", hb, exp_q.pop_front());
    end
    if (pd) begin
      if (busy_pre) m_drop = (m_drop == 8'hFF) ? 8'hFF : m_drop + 8'd1;
      else push_frame(fn, d);
    end
    // commits read the shadow as it stood before this edge's write
    for (int i = 0; i < int'(N); i++) begin
      req = pd && fn == 8'h03 && d[i];
      if (!busy_v[i] && (m_pend[i] || req)) begin
        m_ac_hs[i] = m_sh_hs[i]; m_ac_duty[i] = m_sh_duty[i]; m_ac_gap[i] = m_sh_gap[i];
        m_ac_pnum[i] = m_sh_pnum[i]; m_ac_pat[i] = m_sh_pat[i]; m_ac_ls[i] = m_sh_ls[i];
        m_pend[i] = 1'b0;
      end else if (req) m_pend[i] = 1'b1;
    end
    if (pd && (fn == 8'h01 || fn == 8'h02)) begin
      for (int i = 0; i < int'(N); i++) begin
        if (d[7:0] == 8'hFF || int'(d[7:0]) == i) begin
          if (fn == 8'h01) begin
            m_sh_hs[i] = pkt_byte(d, 2);
            m_sh_duty[i] = pkt_byte(d, 3);
            m_sh_gap[i] = {pkt_byte(d, 4), pkt_byte(d, 5)};
            m_sh_pnum[i] = pkt_byte(d, 6);
            m_sh_pat[i] = 0;
            for (int b = 0; b < int'(PB); b++) m_sh_pat[i] = {m_sh_pat[i][PW-9:0], pkt_byte(d, 7 + b)};
          end else m_sh_ls[i] = pkt_byte(d, 2);
        end
      end
    end
  endtask

  task automatic compare_outputs();
    logic [8*N-1:0] e_hs, e_duty, e_pn, e_ls;
    logic [16*N-1:0] e_gap;
    logic [PW*N-1:0] e_pat;
    for (int i = 0; i < int'(N); i++) begin
      e_hs[8*i +: 8] = m_ac_hs[i];
      e_duty[8*i +: 8] = m_ac_duty[i];
      e_pn[8*i +: 8] = m_ac_pnum[i];
      e_ls[8*i +: 8] = m_ac_ls[i];
      e_gap[16*i +: 16] = m_ac_gap[i];
      e_pat[PW*i +: PW] = m_ac_pat[i];
    end
    check("hs_ctrl_sta", hs_ctrl_sta, e_hs);
    check("duty_num", duty_num, e_duty);
    check("pulse_dessert", pulse_dessert, e_gap);
    check("pulse_num", pulse_num, e_pn);
    check("pat", pat, e_pat);
    check("ls_ctrl_sta", ls_ctrl_sta, e_ls);
    check("commit_pending", commit_pending, m_pend);
    check("drop_cnt", drop_cnt, m_drop);
    check("resp_busy", resp_busy, exp_q.size() != 0);
    check("tx_valid", tx_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) check("tx_data_head", tx_data, exp_q[0]);
  endtask

  // One clock: drive at negedge, let the edge happen, advance model, compare
  task automatic step(input logic pd, input logic [7:0] fn, input logic [87:0] d, input logic rdy);
    logic hs, bp;
    logic [7:0] hb;
    @(negedge clk_50M);
    rst_n = rst_drv; pack_done = pd; func_reg = fn; rev_data = d;
    ch_busy = busy_v; tx_ready = rdy;
    hs = (tx_valid === 1'b1) && rdy;
    hb = tx_data;
    bp = exp_q.size() != 0;
    @(posedge clk_50M);
    #1;
    if (!rst_drv) model_reset();
    else begin
      if (hs) hs_cnt++;
      model_edge(pd, fn, d, hs, hb, bp);
    end
    compare_outputs();
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int k = 0; k < n; k++) step(1'b0, 8'h00, 88'h0, rdy);
  endtask

  task automatic drain();
    int budget;
    budget = 200;
    while (exp_q.size() != 0 && budget > 0) begin
      step(1'b0, 8'h00, 88'h0, 1'b1);
      budget--;
    end
    if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
  endtask

  function automatic logic [87:0] rnd_data(input logic [7:0] ch);
    logic [87:0] d;
    d = {24'($urandom), 32'($urandom), 32'($urandom)};
    d[7:0] = ch;
    return d;
  endfunction

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs0, r;
    logic [7:0] fn, ch;
    model_reset();
    rst_drv = 1'b0;
    idle(3, 1'b1);
    rst_drv = 1'b1;
    idle(2, 1'b1);

    // HS write to channel 2, then commit it
    step(1'b1, 8'h01, {8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h05, 8'h10, 8'h00, 8'h40, 8'h01, 8'h02}, 1'b1);
    drain();
    check("duty2_before_commit", duty_num[23:16], 8'h00);
    step(1'b1, 8'h03, 88'h04, 1'b1);
    check("pat2_commit", pat[95:64], 32'hDEADBEEF);
    check("duty2_commit", duty_num[23:16], 8'h40);
    check("gap2_commit", pulse_dessert[47:32], 16'h0010);
    drain();

    // Broadcast write, commit all, then a bad-channel write
    step(1'b1, 8'h01, {rnd_data(8'hFF)} & ~88'hFF_0000 | 88'h22_0000, 1'b1);
    drain();
    step(1'b1, 8'h03, 88'hFF, 1'b1);
    drain();
    check("bcast_duty", duty_num, 32'h22222222);
    step(1'b1, 8'h01, rnd_data(8'h09), 1'b1);
    drain();
    step(1'b1, 8'h03, 88'hFF, 1'b1);
    drain();
    check("badch_duty", duty_num, 32'h22222222);

    // Deferred commit on busy channel 1
    busy_v = 4'b0010;
    step(1'b1, 8'h03, 88'h02, 1'b1);
    check("pending1_set", commit_pending, 4'b0010);
    drain();
    step(1'b1, 8'h01, {rnd_data(8'h01)} & ~88'hFF_0000 | 88'h33_0000, 1'b1);
    drain();
    check("duty1_while_busy", duty_num[15:8], 8'h22);
    busy_v = 4'b0000;
    idle(1, 1'b1);
    check("duty1_deferred", duty_num[15:8], 8'h33);
    check("pending1_clear", commit_pending, 4'b0000);

    // Readback channel 0 with tx_ready toggling
    hs0 = hs_cnt;
    step(1'b1, 8'h04, 88'h00, 1'b0);
    for (int k = 0; k < 60 && exp_q.size() != 0; k++) step(1'b0, 8'h00, 88'h0, 1'(k % 2));
    check("rb_len", hs_cnt - hs0, RB_LEN);

    // Drops while a frame is outstanding
    drain();
    step(1'b1, 8'h02, rnd_data(8'h00), 1'b0);
    step(1'b1, 8'h01, rnd_data(8'h03), 1'b0);
    check("drop_first", drop_cnt, 8'h01);
    for (int k = 0; k < 300; k++) step(1'b1, 8'h02, rnd_data(8'(k % 4)), 1'b0);
    check("drop_sat", drop_cnt, 8'hFF);
    drain();
    step(1'b1, 8'h03, 88'h0F, 1'b1);
    drain();

    // Unknown function code
    step(1'b1, 8'h07, rnd_data(8'h01), 1'b1);
    drain();

    // Randomised traffic
    for (int k = 0; k < 800; k++) begin
      busy_v = N'($urandom);
      r = $urandom_range(0, 9);
      fn = (r < 3) ? 8'h01 : (r < 5) ? 8'h02 : (r < 7) ? 8'h03 : (r < 9) ? 8'h04 : 8'($urandom);
      r = $urandom_range(0, 6);
      ch = (r == 6) ? 8'hFF : 8'(r);
      if (fn == 8'h03) ch = 8'($urandom);
      step($urandom_range(0, 3) == 0, fn, rnd_data(ch), 1'($urandom_range(0, 3) != 0));
    end
    busy_v = '0;
    drain();

    // Reset in the middle of a readback frame
    step(1'b1, 8'h04, 88'h01, 1'b1);
    idle(3, 1'b1);
    rst_drv = 1'b0;
    idle(1, 1'b1);
    check("rst_tx_valid", tx_valid, 1'b0);
    check("rst_hs", hs_ctrl_sta, 0);
    check("rst_pat", pat, 0);
    check("rst_drop", drop_cnt, 0);
    rst_drv = 1'b1;
    idle(3, 1'b1);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
